pong_score_fsm: RTL
===================

Name: pong_score_fsm

Overview:
- Game-control and scoreboard block for the pong design.
- Produces the four BCD score digits and the game-phase flags that the text overlay and graphics paths consume.
- Counts points from paddle-miss pulses and sequences the game through new-game, play, new-ball and game-over phases using a frame-tick timer.
- Sits between the ball/paddle graphics logic (miss events, frame tick) and the text overlay (digits, rule/over display selection).

Parameters:
WIN_SCORE, 11, decimal points needed to win; legal range 1..99
NEWBALL_TICKS, 120, frame ticks the ball is held after a point (2 s at 60 Hz); legal range 1..255
OVER_TICKS, 180, frame ticks the game-over message is held before returning to new-game; legal range 1..255

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
refr_tick  in  1  one-cycle pulse per video frame
btn_start  in  1  debounced start button level
miss_l  in  1  one-cycle pulse: left paddle missed, right player scores
miss_r  in  1  one-cycle pulse: right paddle missed, left player scores
dig0  out  4  left player ones, BCD
dig1  out  4  left player tens, BCD
dig2  out  4  right player ones, BCD
dig3  out  4  right player tens, BCD
ball_still  out  1  ball held at serve position
show_rules  out  1  new-game phase; overlay shows logo and rules
game_over  out  1  overlay shows "GAME OVER"
winner  out  2  01 left, 10 right, 11 tie, 00 none

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port name reset. The polarity and synchronicity are fixed.
- All outputs are registered. Reset values:
  - state = NEWGAME
  - dig0..dig3 = 0
  - ball_still = 1, show_rules = 1, game_over = 0, winner = 00
  - timer = 0
  - start edge register = 0
- Reset asserted in any state, mid-countdown included, forces these values on the next edge.
- Start detection: a rising edge is btn_start = 1 while the value registered on the previous cycle is 0. A held button produces only one edge.
- NEWGAME state:
  - ball_still = 1, show_rules = 1. Scores are held.
  - On a start edge: clear all digits to 0, set winner = 00, go to PLAY.
- PLAY state:
  - ball_still = 0.
  - miss_r increments the left score (dig1:dig0). miss_l increments the right score (dig3:dig2).
  - If both arrive in the same cycle, both scores increment.
  - Miss pulses outside PLAY are ignored.
  - After any increment, compare the post-increment values against WIN_SCORE (tens = WIN_SCORE/10, ones = WIN_SCORE%10):
    - One or both scores equal WIN_SCORE: set winner, load timer = OVER_TICKS, go to OVER.
    - Otherwise: load timer = NEWBALL_TICKS, go to NEWBALL.
  - Latency: miss pulse at cycle n gives updated digits, state and flags at cycle n+1.
- NEWBALL state:
  - ball_still = 1.
  - timer decrements on each refr_tick.
  - When refr_tick arrives with timer == 1, go to PLAY (timer reaches 0).
  - btn_start is ignored.
- OVER state:
  - game_over = 1, ball_still = 1. Digits and winner are held.
  - timer decrements on refr_tick. Expiry (same rule as NEWBALL) goes to NEWGAME with show_rules = 1 and game_over = 0.
  - Scores stay visible until the next start edge.
- BCD increment:
  - ones 9 -> 0 with tens + 1; otherwise ones + 1.
  - Saturate at 99: no wrap. Not reachable with legal WIN_SCORE; must still hold.
- refr_tick in the same cycle as a state-entry timer load: the load wins and that tick is not counted.
- The timer never underflows. At 0 it holds.
- Illegal state encodings recover to NEWGAME.

Decomposition:
- Shared package pong_pkg:
  - state enum (NEWGAME, PLAY, NEWBALL, OVER)
  - 4-bit BCD digit type
  - winner codes
  - default tick constants
- One sub-module, bcd_score_counter. Two-digit BCD with inputs clk, reset, clr, inc; outputs tens, ones; saturates at 99. Instantiated twice, once per player.
- FSM, timer and start-edge logic stay in pong_score_fsm.

Test Plan:
1. Reset, then btn_start rising -> state PLAY next cycle, digits 0000, ball_still = 0; holding btn_start high for 100 cycles gives no further effect.
2. In PLAY, miss_r pulse -> dig1:dig0 = 0:1 next cycle, ball_still = 1; after exactly 120 refr_ticks ball_still = 0; miss_l during NEWBALL leaves dig3:dig2 = 0:0.
3. Left score at 0:9, miss_r -> dig1:dig0 = 1:0 (BCD carry); with WIN_SCORE = 11, a further point gives 1:1, game_over = 1, winner = 01.
4. Both scores at 1:0, miss_l and miss_r in the same cycle -> both 1:1, winner = 11, state OVER; after 180 refr_ticks show_rules = 1 and digits still 1:1; start edge clears digits to 0000.
5. Reset asserted mid-NEWBALL with timer = 57 -> next cycle state NEWGAME, digits 0, timer 0, all flags at reset values.
6. Force both counters to 9:9 with WIN_SCORE = 99 in a unit test of bcd_score_counter, then apply inc -> value stays 9:9.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game-control logic.
package pong_pkg;

  // Game phases. Any other encoding is treated as corrupt and recovers to ST_NEWGAME.
  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  // One BCD digit.
  typedef logic [3:0] bcd_t;

  // Winner codes. Bit 0 means the left player won and bit 1 means the right player won.
  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;
  localparam logic [1:0] WIN_TIE   = 2'b11;

  // Default game constants. The tick counts assume a 60 Hz frame rate.
  localparam int DEF_WIN_SCORE     = 11;
  localparam int DEF_NEWBALL_TICKS = 120;
  localparam int DEF_OVER_TICKS    = 180;

  // Two-digit BCD increment that saturates at 99. Returns {tens, ones}.
  function automatic logic [7:0] bcd_inc(input bcd_t tens, input bcd_t ones);
    logic [7:0] res;
    if (tens == 4'd9 && ones == 4'd9) begin
      res = {tens, ones};
    end else if (ones == 4'd9) begin
      res = {tens + 4'd1, 4'd0};
    end else begin
      res = {tens, ones + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score counter with a clear input and saturation at 99.
module bcd_score_counter
  import pong_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output bcd_t tens,
  output bcd_t ones
);

  // Score register. A clear takes priority over an increment.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc) begin
      {tens, ones} <= bcd_inc(tens, ones);
    end
  end

endmodule

// File: rtl/pong_score_fsm.sv
// Pong game-phase sequencer and scoreboard.
// Miss pulses score points during PLAY, and frame ticks time the serve delay and the game-over hold.
// Every output is registered. A miss pulse in cycle n shows up on the digits and flags in cycle n+1.
module pong_score_fsm
  import pong_pkg::*;
#(
  parameter int WIN_SCORE     = DEF_WIN_SCORE,
  parameter int NEWBALL_TICKS = DEF_NEWBALL_TICKS,
  parameter int OVER_TICKS    = DEF_OVER_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refr_tick,
  input  logic       btn_start,
  input  logic       miss_l,
  input  logic       miss_r,
  output bcd_t       dig0,
  output bcd_t       dig1,
  output bcd_t       dig2,
  output bcd_t       dig3,
  output logic       ball_still,
  output logic       show_rules,
  output logic       game_over,
  output logic [1:0] winner,
  output state_t     state_dbg,
  output logic [7:0] timer_dbg
);

  localparam bcd_t       WIN_TENS = bcd_t'(WIN_SCORE / 10);
  localparam bcd_t       WIN_ONES = bcd_t'(WIN_SCORE % 10);
  localparam logic [7:0] NB_LOAD  = 8'(NEWBALL_TICKS);
  localparam logic [7:0] OV_LOAD  = 8'(OVER_TICKS);

  state_t     state, state_nxt;
  logic [7:0] timer, timer_nxt;
  logic [1:0] winner_nxt;
  logic       btn_q;
  logic       start_edge;
  logic       clr_scores, inc_l, inc_r;
  logic [7:0] post_l, post_r;
  logic       l_win, r_win;
  bcd_t       l_tens, l_ones, r_tens, r_ones;

  assign start_edge = btn_start & ~btn_q;

  // Left player's score. It is advanced when the right paddle misses.
  bcd_score_counter u_left (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_scores),
    .inc   (inc_l),
    .tens  (l_tens),
    .ones  (l_ones)
  );

  // Right player's score. It is advanced when the left paddle misses.
  bcd_score_counter u_right (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_scores),
    .inc   (inc_r),
    .tens  (r_tens),
    .ones  (r_ones)
  );

  assign dig0      = l_ones;
  assign dig1      = l_tens;
  assign dig2      = r_ones;
  assign dig3      = r_tens;
  assign state_dbg = state;
  assign timer_dbg = timer;

  // Next-state, timer and scoring decisions.
  // The win check uses the post-increment score, so the winning point goes straight to OVER.
  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    winner_nxt = winner;
    clr_scores = 1'b0;
    inc_l      = 1'b0;
    inc_r      = 1'b0;
    post_l     = miss_r ? bcd_inc(l_tens, l_ones) : {l_tens, l_ones};
    post_r     = miss_l ? bcd_inc(r_tens, r_ones) : {r_tens, r_ones};
    l_win      = (post_l == {WIN_TENS, WIN_ONES});
    r_win      = (post_r == {WIN_TENS, WIN_ONES});
    case (state)
      ST_NEWGAME: begin
        if (start_edge) begin
          clr_scores = 1'b1;
          winner_nxt = WIN_NONE;
          state_nxt  = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (miss_l || miss_r) begin
          inc_l = miss_r;
          inc_r = miss_l;
          if (l_win || r_win) begin
            winner_nxt = {r_win, l_win};
            timer_nxt  = OV_LOAD;
            state_nxt  = ST_OVER;
          end else begin
            timer_nxt = NB_LOAD;
            state_nxt = ST_NEWBALL;
          end
        end
      end
      ST_NEWBALL: begin
        if (refr_tick && timer != 8'd0) begin
          timer_nxt = timer - 8'd1;
          if (timer == 8'd1) state_nxt = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (refr_tick && timer != 8'd0) begin
          timer_nxt = timer - 8'd1;
          if (timer == 8'd1) state_nxt = ST_NEWGAME;
        end
      end
      default: begin
        state_nxt = ST_NEWGAME;
        timer_nxt = 8'd0;
      end
    endcase
  end

  // State, timer, start-edge and output-flag registers.
  // The flags are decoded from the next state so that they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_NEWGAME;
      timer      <= 8'd0;
      btn_q      <= 1'b0;
      winner     <= WIN_NONE;
      ball_still <= 1'b1;
      show_rules <= 1'b1;
      game_over  <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      btn_q      <= btn_start;
      winner     <= winner_nxt;
      ball_still <= (state_nxt != ST_PLAY);
      show_rules <= (state_nxt == ST_NEWGAME);
      game_over  <= (state_nxt == ST_OVER);
    end
  end

endmodule
